ps2_keyboard_fifo: RTL and testbench
====================================

Name: ps2_keyboard_fifo

Overview:
Parametrised next-generation PS/2 keyboard receiver for the peripheral bus. It oversamples PS2_clk and PS2_data in the system_clk domain and decodes 11-bit device-to-host frames with parity, stop-bit and timeout checking. Valid scancodes are buffered in a FIFO of configurable depth. A memory-mapped data/status pair is exposed on the 14-bit address / 64-bit data read bus, alongside the other peripherals decoded below VRAM_ADDRESS (14'h3fff).

Parameters:
FIFO_DEPTH, 16, scancode FIFO entries; power of two, 2..256.
ADDR_WIDTH, 14, bus address width.
DATA_WIDTH, 64, read data width; minimum 32.
BASE_ADDRESS, 14'h3ff0, data register address; the status register is at BASE_ADDRESS+1.
TIMEOUT_CYCLES, 20000, system_clk cycles allowed between PS2_clk falling edges inside a frame.
SYNC_STAGES, 2, synchroniser depth for PS2_clk and PS2_data; minimum 2.

Ports:
system_clk  input  1  system clock; all state changes on its rising edge.
reset  input  1  asynchronous, active-low reset.
PS2_clk  input  1  PS/2 clock from the device; asynchronous.
PS2_data  input  1  PS/2 data from the device; asynchronous.
address  input  ADDR_WIDTH  bus read address.
read_strobe  input  1  one-cycle read-commit pulse; qualifies pops and sticky-flag clears.
data  output  DATA_WIDTH  read data; combinational mux on address.
irq  output  1  high while the FIFO is non-empty or any sticky error flag is set.
frame_error  output  1  one-cycle pulse on any rejected frame.

Behaviour:
- Reset (reset=0, asynchronous):
  - FIFO empty; pointers and count 0.
  - Sticky flags 0; error counter 0; FSM in IDLE.
  - Synchroniser flops preset to 1; irq=0; frame_error=0.
  - data follows the address mux and reads as empty/zero content.
- Reset asserted mid-frame discards the partial frame. After release the FSM waits for a new start bit.
- Synchronisers:
  - PS2_clk and PS2_data each pass through SYNC_STAGES flops.
  - A falling edge is detected as sync_clk_prev=1 and sync_clk=0.
  - Data is sampled from sync_data in that same cycle.
- FSM states and transitions (each transition on a detected falling edge):
  - IDLE: sample 0 -> DATA with bit index 0. Sample 1 -> stay in IDLE; this is a glitch and is not an error.
  - DATA: shift the sample in LSB first. After the 8th bit -> PARITY.
  - PARITY: latch the sample -> STOP.
  - STOP: validate the frame -> IDLE.
- Frame validation in STOP:
  - Odd parity: the XOR of the 8 data bits and the parity bit must equal 1.
  - The stop bit must be 1.
  - Valid frame: push the byte in the same cycle; it is visible on the bus the next cycle.
  - Parity fail sets parity_err. Stop fail sets framing_err. Both may be set by the same frame.
  - Any invalid frame pulses frame_error, increments the error counter and pushes nothing.
- Timeout:
  - A counter resets on every falling edge and runs while the FSM is not in IDLE.
  - Reaching TIMEOUT_CYCLES -> IDLE, set timeout_err, pulse frame_error, increment the error counter.
- FIFO:
  - Push while full drops the byte and sets overflow.
  - Pop: read_strobe=1 with address==BASE_ADDRESS and FIFO non-empty. Pop on empty is ignored.
  - Simultaneous push and pop when full: both take effect, count unchanged, no overflow.
  - Simultaneous push and pop when empty: push only; the pop is ignored.
  - Pointers wrap modulo FIFO_DEPTH; count ranges 0..FIFO_DEPTH.
- Data register (address==BASE_ADDRESS):
  - [7:0] head byte; reads 0 when empty.
  - [8] valid (FIFO non-empty).
  - [31:16] count, zero-extended.
  - All other bits 0.
- Status register (address==BASE_ADDRESS+1):
  - [0] empty, [1] full, [2] overflow, [3] parity_err, [4] framing_err, [5] timeout_err.
  - [31:16] error counter, 16-bit, saturating at 16'hffff.
  - All other bits 0.
  - read_strobe at this address clears bits [5:2] and the error counter at the next edge.
  - A new error in the same cycle as the clear wins: its flag is set and the counter reads 1.
- Any other address: data=0. Reads never alter state without read_strobe.

Test Plan:
- Scancode 8'h1C: frame 0,0,0,1,1,1,0,0,0,0,1 (start, data LSB first, parity 0, stop), PS2 half-period 8 system_clk -> data[8]=1, data[7:0]=8'h1C, count=1, irq=1. read_strobe at BASE -> empty=1, irq=0.
- Same frame with parity=1 -> no push, frame_error pulses once, status[3]=1, error counter=1. read_strobe at BASE+1 -> status[5:2]=0, counter=0.
- 17 valid frames 8'h01..8'h11 with FIFO_DEPTH=16 -> full=1, overflow=1. Sixteen pops return 8'h01..8'h10 in order; then empty=1.
- Start plus 4 data bits, then PS2_clk held high for TIMEOUT_CYCLES+2 -> timeout_err=1, FSM in IDLE. A following valid 8'hF0 frame is received correctly.
- FIFO full, pop issued in the same cycle as a stop-bit push of 8'h5A -> count stays 16, overflow=0, 8'h5A is the last entry.
- reset pulsed low after the 5th data bit -> all flags 0, count 0. The next full 8'h1C frame is received correctly.

Source files
------------

// File: rtl/ps2_keyboard_fifo.sv
// PS/2 keyboard receiver: oversampled frame decoder with parity/stop/timeout
// checking, scancode FIFO and a memory-mapped data/status register pair.
module ps2_keyboard_fifo #(
  parameter int unsigned           FIFO_DEPTH     = 16,
  parameter int unsigned           ADDR_WIDTH     = 14,
  parameter int unsigned           DATA_WIDTH     = 64,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDRESS   = 14'h3ff0,
  parameter int unsigned           TIMEOUT_CYCLES = 20000,
  parameter int unsigned           SYNC_STAGES    = 2
) (
  input  logic                  system_clk,
  input  logic                  reset,
  input  logic                  PS2_clk,
  input  logic                  PS2_data,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic                  read_strobe,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  irq,
  output logic                  frame_error
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [ADDR_WIDTH-1:0] STATUS_ADDR = ADDR_WIDTH'(BASE_ADDRESS + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_e;

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d, data_sync_q, data_sync_d;
  logic                   clk_prev_q, clk_prev_d;
  logic [2:0]             bit_idx_q, bit_idx_d;
  logic [7:0]             shreg_q, shreg_d;
  logic                   parity_q, parity_d;
  logic [TMO_W-1:0]       tmo_q, tmo_d;
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic                   ovf_q, ovf_d, par_err_q, par_err_d;
  logic                   frm_err_q, frm_err_d, tmo_err_q, tmo_err_d;
  logic [15:0]            err_cnt_q, err_cnt_d;
  logic                   irq_q, irq_d, frame_error_q, frame_error_d;
  logic [7:0]             mem_q [FIFO_DEPTH];

  logic fall, sample, push, bad_parity, bad_stop, timeout;
  logic pop, clr, full, do_push, err_evt;
  logic [15:0] err_base;
  logic [DATA_WIDTH-1:0] rd_data;

  assign clk_sync_d  = {clk_sync_q[SYNC_STAGES-2:0], PS2_clk};
  assign data_sync_d = {data_sync_q[SYNC_STAGES-2:0], PS2_data};
  assign clk_prev_d  = clk_sync_q[SYNC_STAGES-1];
  assign fall        = clk_prev_q & ~clk_sync_q[SYNC_STAGES-1];
  assign sample      = data_sync_q[SYNC_STAGES-1];

  // Frame decoder; every transition is qualified by a synchronised falling edge.
  always_comb begin
    state_d    = state_q;
    bit_idx_d  = bit_idx_q;
    shreg_d    = shreg_q;
    parity_d   = parity_q;
    tmo_d      = '0;
    push       = 1'b0;
    bad_parity = 1'b0;
    bad_stop   = 1'b0;
    timeout    = 1'b0;
    if (fall) begin
      unique case (state_q)
        IDLE: if (!sample) begin
          state_d   = DATA;
          bit_idx_d = 3'd0;
        end
        DATA: begin
          shreg_d   = {sample, shreg_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) state_d = PARITY;
        end
        PARITY: begin
          parity_d = sample;
          state_d  = STOP;
        end
        STOP: begin
          state_d    = IDLE;
          bad_parity = ~(^{shreg_q, parity_q});
          bad_stop   = ~sample;
          push       = ~bad_parity & ~bad_stop;
        end
        default: state_d = IDLE;
      endcase
    end else if (state_q != IDLE) begin
      if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
        timeout = 1'b1;
        state_d = IDLE;
      end else begin
        tmo_d = tmo_q + TMO_W'(1);
      end
    end
  end

  // FIFO bookkeeping, sticky flags and the saturating error counter.
  always_comb begin
    pop     = read_strobe && (address == BASE_ADDRESS) && (count_q != '0);
    clr     = read_strobe && (address == STATUS_ADDR);
    full    = (count_q == CNT_W'(FIFO_DEPTH));
    do_push = push && (!full || pop);
    err_evt = bad_parity | bad_stop | timeout;

    wr_ptr_d = do_push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d  = count_q;
    if (do_push && !pop) count_d = count_q + CNT_W'(1);
    if (!do_push && pop) count_d = count_q - CNT_W'(1);

    // A fresh error in the clearing cycle survives the clear.
    ovf_d     = (clr ? 1'b0 : ovf_q) | (push && full && !pop);
    par_err_d = (clr ? 1'b0 : par_err_q) | bad_parity;
    frm_err_d = (clr ? 1'b0 : frm_err_q) | bad_stop;
    tmo_err_d = (clr ? 1'b0 : tmo_err_q) | timeout;
    err_base  = clr ? 16'h0000 : err_cnt_q;
    err_cnt_d = (err_evt && err_base != 16'hffff) ? err_base + 16'd1 : err_base;

    irq_d         = (count_d != '0) | ovf_d | par_err_d | frm_err_d | tmo_err_d;
    frame_error_d = err_evt;
  end

  always_ff @(posedge system_clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      clk_sync_q    <= '1;
      data_sync_q   <= '1;
      clk_prev_q    <= 1'b1;
      bit_idx_q     <= '0;
      shreg_q       <= '0;
      parity_q      <= 1'b0;
      tmo_q         <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      ovf_q         <= 1'b0;
      par_err_q     <= 1'b0;
      frm_err_q     <= 1'b0;
      tmo_err_q     <= 1'b0;
      err_cnt_q     <= '0;
      irq_q         <= 1'b0;
      frame_error_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      clk_sync_q    <= clk_sync_d;
      data_sync_q   <= data_sync_d;
      clk_prev_q    <= clk_prev_d;
      bit_idx_q     <= bit_idx_d;
      shreg_q       <= shreg_d;
      parity_q      <= parity_d;
      tmo_q         <= tmo_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      ovf_q         <= ovf_d;
      par_err_q     <= par_err_d;
      frm_err_q     <= frm_err_d;
      tmo_err_q     <= tmo_err_d;
      err_cnt_q     <= err_cnt_d;
      irq_q         <= irq_d;
      frame_error_q <= frame_error_d;
    end
  end

  // Storage array carries no reset; the valid bit masks stale entries.
  always_ff @(posedge system_clk) begin
    if (do_push) mem_q[wr_ptr_q] <= shreg_q;
  end

  always_comb begin
    rd_data = '0;
    if (address == BASE_ADDRESS) begin
      rd_data[7:0]   = (count_q != '0) ? mem_q[rd_ptr_q] : 8'h00;
      rd_data[8]     = (count_q != '0);
      rd_data[31:16] = 16'(count_q);
    end else if (address == STATUS_ADDR) begin
      rd_data[0]     = (count_q == '0);
      rd_data[1]     = full;
      rd_data[2]     = ovf_q;
      rd_data[3]     = par_err_q;
      rd_data[4]     = frm_err_q;
      rd_data[5]     = tmo_err_q;
      rd_data[31:16] = err_cnt_q;
    end
  end

  assign data        = rd_data;
  assign irq         = irq_q;
  assign frame_error = frame_error_q;

endmodule

// File: tb/tb_ps2_keyboard_fifo.sv
// Self-checking bench for ps2_keyboard_fifo: directed and random PS/2 frames
// compared against a queue-based model of the register interface.
module tb_ps2_keyboard_fifo;

  localparam int unsigned DEPTH   = 16;
  localparam int unsigned TIMEOUT = 20000;
  localparam logic [13:0] BASE    = 14'h3ff0;
  localparam logic [13:0] STAT    = 14'h3ff1;
  localparam logic [13:0] OTHER   = 14'h0123;

  logic        system_clk = 1'b0;
  logic        reset;
  logic        PS2_clk;
  logic        PS2_data;
  logic [13:0] address;
  logic        read_strobe;
  logic [63:0] data;
  logic        irq;
  logic        frame_error;

  ps2_keyboard_fifo #(
    .FIFO_DEPTH(DEPTH), .ADDR_WIDTH(14), .DATA_WIDTH(64),
    .BASE_ADDRESS(BASE), .TIMEOUT_CYCLES(TIMEOUT), .SYNC_STAGES(2)
  ) dut (
    .system_clk(system_clk), .reset(reset), .PS2_clk(PS2_clk), .PS2_data(PS2_data),
    .address(address), .read_strobe(read_strobe), .data(data), .irq(irq),
    .frame_error(frame_error)
  );

  always #5 system_clk = ~system_clk;

  int fe_cnt = 0;
  always @(posedge system_clk) if (frame_error === 1'b1) fe_cnt <= fe_cnt + 1;

  int vectors = 0;
  int miscompares = 0;

  // Reference model
  logic [7:0] q[$];
  bit m_ovf, m_par, m_frm, m_tmo;
  int m_err, exp_fe;
  logic [63:0] strobe_obs;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] exp_data();
    logic [63:0] r = '0;
    if (q.size() > 0) begin
      r[7:0] = q[0];
      r[8]   = 1'b1;
    end
    r[31:16] = 16'(q.size());
    return r;
  endfunction

  function automatic logic [63:0] exp_status();
    logic [63:0] r = '0;
    r[0] = (q.size() == 0);
    r[1] = (q.size() == DEPTH);
    r[2] = m_ovf; r[3] = m_par; r[4] = m_frm; r[5] = m_tmo;
    r[31:16] = 16'(m_err);
    return r;
  endfunction

  function automatic logic exp_irq();
    return (q.size() != 0) || m_ovf || m_par || m_frm || m_tmo;
  endfunction

  task automatic model_reset();
    q.delete();
    m_ovf = 0; m_par = 0; m_frm = 0; m_tmo = 0; m_err = 0;
  endtask

  task automatic model_err();
    if (m_err < 65535) m_err++;
    exp_fe++;
  endtask

  task automatic model_frame(input logic [7:0] b, input logic par, input logic stop);
    logic odd_ok;
    odd_ok = ((^b) ^ par) == 1'b1;
    if (odd_ok && stop) begin
      if (q.size() == DEPTH) m_ovf = 1;
      else q.push_back(b);
    end else begin
      if (!odd_ok) m_par = 1;
      if (!stop) m_frm = 1;
      model_err();
    end
  endtask

  task automatic model_pop();
    if (q.size() > 0) void'(q.pop_front());
  endtask

  task automatic model_clear();
    m_ovf = 0; m_par = 0; m_frm = 0; m_tmo = 0; m_err = 0;
  endtask

  task automatic read_reg(input logic [13:0] a, input logic s, output logic [63:0] obs);
    @(negedge system_clk);
    address = a; read_strobe = s;
    #1 obs = data;
    @(negedge system_clk);
    read_strobe = 1'b0; address = '0;
  endtask

  task automatic check_all(input string tag);
    logic [63:0] obs;
    read_reg(BASE, 1'b0, obs);  chk({tag, "/data"}, obs, exp_data());
    read_reg(STAT, 1'b0, obs);  chk({tag, "/status"}, obs, exp_status());
    read_reg(OTHER, 1'b0, obs); chk({tag, "/other"}, obs, 64'h0);
    chk({tag, "/irq"}, 64'(irq), 64'(exp_irq()));
    chk({tag, "/fe_pulses"}, 64'(fe_cnt), 64'(exp_fe));
  endtask

  task automatic pop_check(input string tag);
    logic [63:0] obs;
    read_reg(BASE, 1'b1, obs);
    chk(tag, obs, exp_data());
    model_pop();
  endtask

  task automatic clear_check(input string tag);
    logic [63:0] obs;
    read_reg(STAT, 1'b1, obs);
    chk(tag, obs, exp_status());
    model_clear();
  endtask

  // One PS/2 bit: data set while clock high, then 8-cycle low phase.
  // Optional strobe lands on the edge that consumes this bit's falling edge.
  task automatic send_bit(input logic b, input logic hook, input logic [13:0] haddr);
    PS2_data = b;
    repeat (8) @(negedge system_clk);
    PS2_clk = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge system_clk);
      if (hook && i == 2) begin
        address = haddr; read_strobe = 1'b1;
        #1 strobe_obs = data;
      end
      if (hook && i == 3) begin
        read_strobe = 1'b0; address = '0;
      end
    end
    PS2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic par, input logic stop,
                            input logic hook, input logic [13:0] haddr);
    send_bit(1'b0, 1'b0, '0);
    for (int i = 0; i < 8; i++) send_bit(b[i], 1'b0, '0);
    send_bit(par, 1'b0, '0);
    send_bit(stop, hook, haddr);
    repeat (4) @(negedge system_clk);
  endtask

  task automatic good_frame(input logic [7:0] b);
    send_frame(b, ~^b, 1'b1, 1'b0, '0);
    model_frame(b, ~^b, 1'b1);
  endtask

  initial begin
    logic [7:0]  b;
    logic [63:0] exp_head;
    logic [63:0] obs;
    logic        bp, bs;
    int          r;

    reset = 1'b0; PS2_clk = 1'b1; PS2_data = 1'b1;
    address = '0; read_strobe = 1'b0;
    model_reset(); exp_fe = 0;
    repeat (3) @(negedge system_clk);
    check_all("in_reset");
    reset = 1'b1;
    repeat (2) @(negedge system_clk);
    check_all("after_reset");

    // Basic scancode receive and pop
    good_frame(8'h1C);
    check_all("rx_1c");
    pop_check("pop_1c");
    check_all("empty_after_pop");

    // Parity error, then an error arriving on the clearing cycle
    send_frame(8'h1C, 1'b1, 1'b1, 1'b0, '0);
    model_frame(8'h1C, 1'b1, 1'b1);
    check_all("parity_err");
    exp_head = exp_status();
    send_frame(8'h33, 1'b1, 1'b1, 1'b1, STAT);
    chk("clear_race_read", strobe_obs, exp_head);
    model_clear();
    model_frame(8'h33, 1'b1, 1'b1);
    check_all("clear_race");
    clear_check("clear_flags");
    check_all("cleared");

    // Overflow with 17 frames, then ordered drain
    for (int i = 1; i <= 17; i++) good_frame(8'(i));
    check_all("overflow");
    for (int i = 0; i < 16; i++) pop_check("drain_ovf");
    check_all("drained");
    pop_check("pop_on_empty");
    check_all("pop_on_empty_state");
    clear_check("clear_ovf");

    // Timeout mid-frame, then recovery
    send_bit(1'b0, 1'b0, '0);
    for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b0, '0);
    repeat (TIMEOUT + 10) @(negedge system_clk);
    m_tmo = 1; model_err();
    check_all("timeout");
    good_frame(8'hF0);
    check_all("after_timeout");
    pop_check("pop_f0");
    clear_check("clear_tmo");

    // Full FIFO with pop coinciding with the stop-bit push
    for (int i = 0; i < 16; i++) good_frame(8'($urandom));
    check_all("full");
    exp_head = exp_data();
    send_frame(8'h5A, ~^8'h5A, 1'b1, 1'b1, BASE);
    chk("pop_push_read", strobe_obs, exp_head);
    model_pop();
    model_frame(8'h5A, ~^8'h5A, 1'b1);
    check_all("pop_push_full");
    for (int i = 0; i < 16; i++) begin
      read_reg(BASE, 1'b1, obs);
      chk("drain_full", obs, exp_data());
      model_pop();
    end
    chk("last_entry", 64'(obs[7:0]), 64'h5A);
    check_all("drained_full");

    // Reset in the middle of a frame
    good_frame(8'h77);
    send_frame(8'h11, 1'b1, 1'b0, 1'b0, '0);
    model_frame(8'h11, 1'b1, 1'b0);
    send_bit(1'b0, 1'b0, '0);
    b = 8'h1C;
    for (int i = 0; i < 5; i++) send_bit(b[i], 1'b0, '0);
    @(negedge system_clk);
    reset = 1'b0;
    repeat (3) @(negedge system_clk);
    reset = 1'b1;
    model_reset();
    check_all("mid_frame_reset");
    good_frame(8'h1C);
    check_all("rx_after_reset");

    // Random frames with random errors, pops and clears
    for (int it = 0; it < 24; it++) begin
      b  = 8'($urandom);
      bp = ($urandom_range(0, 4) == 0);
      bs = ($urandom_range(0, 5) == 0);
      send_frame(b, (~^b) ^ bp, ~bs, 1'b0, '0);
      model_frame(b, (~^b) ^ bp, ~bs);
      check_all("random");
      r = int'($urandom_range(0, 3));
      if (r <= 1) pop_check("random_pop");
      else if (r == 2) clear_check("random_clear");
    end
    check_all("final");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
